// File: rtl/counting_sched_if.sv
// counting_sched_if: symbol request/grant and hit report bundle for counting_sched
interface counting_sched_if #(parameter int IDW = 2);
  localparam int CH = 1 << IDW;
  logic [CH-1:0] req, clr, gnt, ans;
  logic [2*CH-1:0] num;
  logic hit;
  logic [IDW-1:0] hit_id;
  modport master (output req, num, clr, input gnt, ans, hit, hit_id);
  modport slave (input req, num, clr, output gnt, ans, hit, hit_id);
endinterface

// File: rtl/counting_sched.sv
// counting_sched: round-robin sharing of one 1-2-3 sequence detector across CH saved channel contexts
module counting_sched #(parameter int IDW = 2) (
  input logic clk,
  input logic reset,
  counting_sched_if.slave bus
);
  localparam int CH = 1 << IDW;
  logic [CH-1:0][1:0] ctx_q, ctx_d;
  logic [IDW-1:0] ptr_q, ptr_d, hit_id_q, hit_id_d, g, idx;
  logic hit_q, hit_d, any, take;
  logic [1:0] sym, cur, nxt;
  // rotating-priority search: first requester at or above ptr_q, wrapping
  always_comb begin
    any = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < CH; k++) begin
      idx = ptr_q + k[IDW-1:0];
      if (!any && bus.req[idx]) begin
        any = 1'b1;
        g = idx;
      end
    end
  end
  assign take = any && !reset;
  assign bus.gnt = take ? CH'(1) << g : '0;
  assign cur = ctx_q[g];
  assign sym = bus.num[2*g +: 2];
  assign nxt = sym == 2'd1 ? 2'd1 :
               sym == 2'd2 ? ((cur == 2'd1 || cur == 2'd2) ? 2'd2 : 2'd0) :
               sym == 2'd3 ? (cur[1] ? 2'd3 : 2'd0) : 2'd0;
  // next contexts: clear wins over the granted update, pointer moves past the winner
  always_comb begin
    for (int i = 0; i < CH; i++)
      ctx_d[i] = bus.clr[i] ? 2'd0 : (take && g == i[IDW-1:0]) ? nxt : ctx_q[i];
    ptr_d = take ? g + 1'b1 : ptr_q;
    hit_d = take && !bus.clr[g] && nxt == 2'd3;
    hit_id_d = take ? g : hit_id_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q <= '0;
      ptr_q <= '0;
      hit_q <= 1'b0;
      hit_id_q <= '0;
    end else begin
      ctx_q <= ctx_d;
      ptr_q <= ptr_d;
      hit_q <= hit_d;
      hit_id_q <= hit_id_d;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ans
    assign bus.ans[i] = &ctx_q[i];
  end
  assign bus.hit = hit_q;
  assign bus.hit_id = hit_id_q;
endmodule

// File: tb/tb_counting_sched.sv
// tb_counting_sched: scenario tasks plus a scoreboard of per-cycle hit/hit_id/ans predictions
module tb_counting_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  counting_sched_if #(.IDW(2)) bus ();
  counting_sched #(.IDW(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic hit;
    logic [1:0] hid;
    logic [3:0] ans;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [1:0] m_ctx [4];
  int m_ptr = 0;
  logic [1:0] m_hid = 2'd0;

  function automatic logic [1:0] mnext(input logic [1:0] s, input logic [1:0] n);
    logic [7:0] row;
    row = s == 2'd0 ? 8'b00000100 : s == 2'd1 ? 8'b00100100 : s == 2'd2 ? 8'b11100100 : 8'b11000100;
    return row[2*n +: 2];
  endfunction

  function automatic int mgrant(input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] sym(input int ch, input logic [1:0] v);
    return {6'b0, v} << (2 * ch);
  endfunction

  task automatic set_in(input logic rs, input logic [3:0] r, input logic [7:0] n, input logic [3:0] c);
    @(negedge clk);
    reset = rs;
    bus.req = r;
    bus.num = n;
    bus.clr = c;
    #1;
  endtask

  task automatic commit();
    exp_t e;
    int g;
    logic [1:0] nx;
    e.hit = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_ctx[i] = 2'd0;
      m_ptr = 0;
      m_hid = 2'd0;
    end else begin
      g = mgrant(bus.req);
      nx = g >= 0 ? mnext(m_ctx[g], bus.num[2*g +: 2]) : 2'd0;
      for (int i = 0; i < 4; i++) if (bus.clr[i]) m_ctx[i] = 2'd0;
      if (g >= 0) begin
        if (!bus.clr[g]) m_ctx[g] = nx;
        e.hit = !bus.clr[g] && nx == 2'd3;
        m_hid = g[1:0];
        m_ptr = (g + 1) % 4;
      end
    end
    e.hid = m_hid;
    for (int i = 0; i < 4; i++) e.ans[i] = m_ctx[i] == 2'd3;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      tests++;
      if ({bus.hit, bus.hit_id, bus.ans} !== me) begin
        fails++;
        $display("FAIL scoreboard @%0t: got hit=%b id=%0d ans=%b expected hit=%b id=%0d ans=%b",
                 $time, bus.hit, bus.hit_id, bus.ans, me.hit, me.hid, me.ans);
      end
    end
  end

  task automatic do_reset();
    set_in(1'b1, 4'h0, 8'h00, 4'h0);
    commit();
  endtask

  task automatic test_reset();
    set_in(1'b1, 4'hF, 8'hFF, 4'h0);
    tests++;
    if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    commit();
    tests++;
    if (bus.ans !== 4'b0000 || bus.hit !== 1'b0 || bus.hit_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got ans=%b hit=%b id=%0d expected ans=0000 hit=0 id=0", bus.ans, bus.hit, bus.hit_id);
    end
  endtask

  task automatic test_seq();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0, 4'b0001, sym(0, k[1:0]), 4'h0);
      tests++;
      if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL seq_gnt[%0d]: got %b expected 0001", k, bus.gnt); end
      commit();
    end
    tests++;
    if (bus.hit !== 1'b1 || bus.hit_id !== 2'd0 || bus.ans !== 4'b0001) begin
      fails++;
      $display("FAIL seq_hit: got hit=%b id=%0d ans=%b expected hit=1 id=0 ans=0001", bus.hit, bus.hit_id, bus.ans);
    end
    set_in(1'b0, 4'h0, 8'h00, 4'h0);
    tests++;
    if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL idle_gnt: got %b expected 0000", bus.gnt); end
    commit();
    tests++;
    if (bus.hit !== 1'b0 || bus.ans !== 4'b0001) begin
      fails++;
      $display("FAIL seq_idle: got hit=%b ans=%b expected hit=0 ans=0001", bus.hit, bus.ans);
    end
  endtask

  task automatic test_rr();
    int ord [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, 4'hF, 8'h00, 4'h0);
      tests++;
      if (bus.gnt !== 4'(1 << ord[k])) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %b expected ch%0d", k, bus.gnt, ord[k]);
      end
      commit();
    end
  endtask

  task automatic test_two();
    logic [1:0] a [3] = '{2'd1, 2'd2, 2'd3};
    logic [1:0] b [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    int eg [7] = '{1, 2, 1, 2, 1, 2, 2};
    int ia = 0;
    int ib = 0;
    logic eh;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_in(1'b0, {1'b0, ib < 4, ia < 3, 1'b0},
             sym(1, a[ia < 3 ? ia : 0]) | sym(2, b[ib < 4 ? ib : 0]), 4'h0);
      tests++;
      if (bus.gnt !== 4'(1 << eg[k])) begin
        fails++;
        $display("FAIL two_gnt[%0d]: got %b expected ch%0d", k, bus.gnt, eg[k]);
      end
      if (eg[k] == 1) ia++; else ib++;
      commit();
      eh = (k == 4 || k == 6);
      tests++;
      if (bus.hit !== eh || (eh && bus.hit_id !== 2'(eg[k]))) begin
        fails++;
        $display("FAIL two_hit[%0d]: got hit=%b id=%0d expected hit=%b id=%0d", k, bus.hit, bus.hit_id, eh, eg[k]);
      end
    end
    tests++;
    if (bus.ans !== 4'b0110) begin fails++; $display("FAIL two_ans: got %b expected 0110", bus.ans); end
  endtask

  task automatic test_s3();
    logic [1:0] s [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
    logic eh [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 4'b0001, sym(0, s[k]), 4'h0);
      commit();
      tests++;
      if (bus.hit !== eh[k] || bus.ans[0] !== eh[k]) begin
        fails++;
        $display("FAIL s3_step[%0d]: got hit=%b ans0=%b expected %b/%b", k, bus.hit, bus.ans[0], eh[k], eh[k]);
      end
    end
  endtask

  task automatic test_clr();
    do_reset();
    set_in(1'b0, 4'b1000, sym(3, 2'd1), 4'h0);
    commit();
    set_in(1'b0, 4'b1000, sym(3, 2'd2), 4'h0);
    commit();
    set_in(1'b0, 4'b1000, sym(3, 2'd3), 4'b1000);
    tests++;
    if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL clr_gnt: got %b expected 1000", bus.gnt); end
    commit();
    tests++;
    if (bus.hit !== 1'b0 || bus.ans[3] !== 1'b0) begin
      fails++;
      $display("FAIL clr_ctx: got hit=%b ans3=%b expected 0/0", bus.hit, bus.ans[3]);
    end
    set_in(1'b0, 4'hF, 8'h00, 4'h0);
    tests++;
    if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL clr_ptr: got %b expected 0001", bus.gnt); end
    commit();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b0, 4'b0100, sym(2, k[1:0]), 4'h0);
      commit();
    end
    for (int k = 1; k <= 2; k++) begin
      set_in(1'b0, 4'b0001, sym(0, k[1:0]), 4'h0);
      commit();
    end
    set_in(1'b1, 4'b0101, sym(0, 2'd3) | sym(2, 2'd3), 4'h0);
    tests++;
    if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL mid_gnt: got %b expected 0000", bus.gnt); end
    commit();
    tests++;
    if (bus.ans !== 4'b0000 || bus.hit !== 1'b0) begin
      fails++;
      $display("FAIL mid_state: got ans=%b hit=%b expected 0000/0", bus.ans, bus.hit);
    end
    set_in(1'b0, 4'b0101, sym(0, 2'd3) | sym(2, 2'd3), 4'h0);
    tests++;
    if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL mid_ptr: got %b expected 0001", bus.gnt); end
    commit();
  endtask

  initial begin
    bus.req = '0;
    bus.num = '0;
    bus.clr = '0;
    test_reset();
    test_seq();
    test_rr();
    test_two();
    test_s3();
    test_clr();
    test_reset_mid();
    set_in(1'b0, 4'h0, 8'h00, 4'h0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
